// File: rtl/aes_key_expander_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expander_if
// Purpose  : Bundles the key-load handshake, the status flags and the
//            round-key read port of aes_key_expander.
// Ports    : master - key source / round datapath (drives key_in, key_valid,
//                     rk_addr; observes status and rk_data)
//            slave  - the key expander itself
// Revision : 1.0 - initial release
// ============================================================================
interface aes_key_expander_if #(
  parameter int ADDR_W = 4
);
  logic [127:0]      key_in;
  logic              key_valid;
  logic              key_ready;
  logic              busy;
  logic              done;
  logic              keys_valid;
  logic [ADDR_W-1:0] rk_addr;
  logic [127:0]      rk_data;

  modport master (
    output key_in, key_valid, rk_addr,
    input  key_ready, busy, done, keys_valid, rk_data
  );

  modport slave (
    input  key_in, key_valid, rk_addr,
    output key_ready, busy, done, keys_valid, rk_data
  );
endinterface
`default_nettype wire

// File: rtl/aes_key_expander.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expander
// Purpose  : Iterative AES-128 key schedule. A cipher key accepted through a
//            valid/ready handshake is expanded into 11 round keys, one per
//            clock, using a single shared round-key step. Keys are served
//            through a registered read port (1-cycle latency).
// Ports    : clk  - rising-edge clock
//            rst  - synchronous reset, active-high
//            bus  - aes_key_expander_if.slave:
//                   key_in/key_valid/key_ready  key load handshake
//                   busy/done/keys_valid        status
//                   rk_addr/rk_data             round-key read port
// Revision : 1.0 - initial release
// ============================================================================
module aes_key_expander #(
  parameter int NR     = 10,
  parameter int ADDR_W = 4
) (
  input logic                clk,
  input logic                rst,
  aes_key_expander_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NR);

  // FIPS-197 S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte b sits at bit offset 8*(255-b); 255-b is simply ~b.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [ADDR_W-1:0] idx);
    logic [7:0] rc;
    rc = 8'h00;
    case (idx)
      ADDR_W'(1):  rc = 8'h01;
      ADDR_W'(2):  rc = 8'h02;
      ADDR_W'(3):  rc = 8'h04;
      ADDR_W'(4):  rc = 8'h08;
      ADDR_W'(5):  rc = 8'h10;
      ADDR_W'(6):  rc = 8'h20;
      ADDR_W'(7):  rc = 8'h40;
      ADDR_W'(8):  rc = 8'h80;
      ADDR_W'(9):  rc = 8'h1b;
      ADDR_W'(10): rc = 8'h36;
      default:     rc = 8'h00;
    endcase
    return rc;
  endfunction

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ctr;
  logic [127:0]      rk [0:NR];
  logic              done_q;
  logic              keys_valid_q;
  logic [127:0]      rk_data_q;

  logic              accept;
  logic [ADDR_W-1:0] prev_idx;
  logic [127:0]      prev_key;
  logic [31:0]       rot_word;
  logic [31:0]       sub_word;
  logic [31:0]       t_word;
  logic [31:0]       n0, n1, n2, n3;
  logic [127:0]      next_key;

  // --------------------------------------------------------------------------
  // Handshake and status
  // --------------------------------------------------------------------------
  assign accept         = bus.key_valid && (state == IDLE);
  assign bus.key_ready  = (state == IDLE);
  assign bus.busy       = (state == EXPAND);
  assign bus.done       = done_q;
  assign bus.keys_valid = keys_valid_q;
  assign bus.rk_data    = rk_data_q;

  // --------------------------------------------------------------------------
  // Shared round-key step: always derived from the entry just below ctr
  // --------------------------------------------------------------------------
  assign prev_idx = ctr - ADDR_W'(1);
  assign prev_key = rk[prev_idx];
  assign rot_word = {prev_key[23:0], prev_key[31:24]};
  assign sub_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                     sbox(rot_word[15:8]),  sbox(rot_word[7:0])};
  assign t_word   = sub_word ^ {rcon(ctr), 24'h000000};
  assign n0       = prev_key[127:96] ^ t_word;
  assign n1       = prev_key[95:64]  ^ n0;
  assign n2       = prev_key[63:32]  ^ n1;
  assign n3       = prev_key[31:0]   ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.key_valid) state_next = EXPAND;
      EXPAND:  if (ctr == LAST_IDX) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Key table, counter, status registers and read port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr          <= '0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      rk_data_q    <= '0;
      for (int i = 0; i <= NR; i++) begin
        rk[i] <= '0;
      end
    end else begin
      // Non-blocking read: a same-cycle write to this entry is not visible yet.
      rk_data_q <= (bus.rk_addr <= LAST_IDX) ? rk[bus.rk_addr] : '0;
      done_q    <= (state == EXPAND) && (ctr == LAST_IDX);

      if (accept) begin
        rk[0]        <= bus.key_in;
        ctr          <= ADDR_W'(1);
        keys_valid_q <= 1'b0;
      end else if (state == EXPAND) begin
        rk[ctr] <= next_key;
        if (ctr == LAST_IDX) begin
          ctr          <= '0;
          keys_valid_q <= 1'b1;
        end else begin
          ctr <= ctr + ADDR_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expander.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_expander
// Purpose  : Self-checking bench for aes_key_expander. A word-oriented
//            FIPS-197 key-expansion model (S-box derived from GF(2^8)
//            inversion plus the affine map) predicts status flags, table
//            contents and read data every cycle; directed vectors pin the
//            model and the DUT against published round keys.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_key_expander;

  localparam int ADDR_W = 4;

  localparam logic [127:0] KEY_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_B     = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] B_RK1     = 128'he232fcf191129188b159e4e6d679a293;
  localparam logic [127:0] B_RK10    = 128'h28fddef86da4244accc0a4fe3b316f26;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_key_expander_if #(.ADDR_W(ADDR_W)) bus ();

  aes_key_expander #(.NR(10), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // --------------------------------------------------------------------------
  // Reference model: S-box from first principles, word-based expansion
  // --------------------------------------------------------------------------
  logic [7:0] sbox_tab [0:255];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int x = 1; x < 256; x++) begin
        if (gf_mul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_tab[a] = s;
    end
  endtask

  logic [127:0] m_exp [0:10];

  task automatic compute_schedule(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]}
            ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) m_exp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Timeline model: m_age = edges since the accept edge, -1 when idle.
  logic [127:0] m_tbl [0:10];
  logic [127:0] m_rd   = '0;
  logic         m_done = 1'b0;
  logic         m_kv   = 1'b0;
  logic         m_init = 1'b0;
  int           m_age  = -1;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_init = 1'b1;
        m_age  = -1;
        m_done = 1'b0;
        m_kv   = 1'b0;
        m_rd   = '0;
        for (int i = 0; i <= 10; i++) m_tbl[i] = '0;
      end else if (m_init) begin
        m_rd = (int'(bus.rk_addr) <= 10) ? m_tbl[bus.rk_addr] : '0;
        if (m_age < 0) begin
          if (bus.key_valid) begin
            compute_schedule(bus.key_in);
            m_tbl[0] = bus.key_in;
            m_age    = 0;
            m_kv     = 1'b0;
          end
        end else if (m_age < 10) begin
          m_age++;
          m_tbl[m_age] = m_exp[m_age];
          if (m_age == 10) begin
            m_done = 1'b1;
            m_kv   = 1'b1;
          end
        end else begin
          m_done = 1'b0;
          m_age  = -1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        check("key_ready",  bus.key_ready,  m_age < 0);
        check("busy",       bus.busy,       (m_age >= 0) && (m_age < 10));
        check("done",       bus.done,       m_done);
        check("keys_valid", bus.keys_valid, m_kv);
        check("rk_data",    bus.rk_data,    m_rd);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus (all driving happens 1 time unit after a rising edge)
  // --------------------------------------------------------------------------
  task automatic read_rk(input logic [ADDR_W-1:0] a, output logic [127:0] d);
    bus.rk_addr = a;
    @(posedge clk);
    #1;
    d = bus.rk_data;
  endtask

  task automatic start_key(input logic [127:0] k, input bit hold);
    int g = 0;
    bus.key_in    = k;
    bus.key_valid = 1'b1;
    while (!bus.key_ready && g < 40) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("accept_ready", bus.key_ready, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) bus.key_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus.done && cyc < 40);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    int           cyc;

    bus.key_in    = '0;
    bus.key_valid = 1'b0;
    bus.rk_addr   = '0;
    build_sbox();
    check("model_sbox_00", sbox_tab[8'h00], 8'h63);
    check("model_sbox_53", sbox_tab[8'h53], 8'hed);

    // 1: reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_key_ready",  bus.key_ready,  1'b1);
    check("rst_busy",       bus.busy,       1'b0);
    check("rst_done",       bus.done,       1'b0);
    check("rst_keys_valid", bus.keys_valid, 1'b0);
    for (int a = 0; a < 16; a++) begin
      read_rk(ADDR_W'(a), d);
      check("rst_rk_data", d, '0);
    end

    // 2: FIPS-197 key
    start_key(KEY_FIPS, 1'b0);
    check("model_fips_rk1",  m_exp[1],  FIPS_RK1);
    check("model_fips_rk10", m_exp[10], FIPS_RK10);
    wait_done(cyc);
    check("fips_latency", 128'(cyc), 128'd10);
    check("fips_keys_valid", bus.keys_valid, 1'b1);
    read_rk(4'd0, d);  check("fips_rk0", d, KEY_FIPS);
    read_rk(4'd1, d);  check("fips_rk1", d, FIPS_RK1);
    read_rk(4'd10, d); check("fips_rk10", d, FIPS_RK10);

    // 3: second published key
    start_key(KEY_B, 1'b0);
    check("model_b_rk1", m_exp[1], B_RK1);
    wait_done(cyc);
    check("b_latency", 128'(cyc), 128'd10);
    read_rk(4'd0, d);  check("b_rk0", d, KEY_B);
    read_rk(4'd1, d);  check("b_rk1", d, B_RK1);
    read_rk(4'd10, d); check("b_rk10", d, B_RK10);

    // 4: all-zero key and out-of-range addresses
    start_key('0, 1'b0);
    check("model_zero_rk10", m_exp[10], ZERO_RK10);
    wait_done(cyc);
    read_rk(4'd10, d); check("zero_rk10", d, ZERO_RK10);
    for (int a = 11; a < 16; a++) begin
      read_rk(ADDR_W'(a), d);
      check("oor_rk_data", d, '0);
    end

    // 5a: a different key pulsed during EXPAND is ignored
    start_key(KEY_FIPS, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    bus.key_in    = KEY_B;
    bus.key_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    wait_done(cyc);
    read_rk(4'd1, d);  check("ignore_rk1", d, FIPS_RK1);
    read_rk(4'd10, d); check("ignore_rk10", d, FIPS_RK10);

    // 5b: back-to-back keys with key_valid held high
    bus.rk_addr = 4'd10;
    start_key(KEY_B, 1'b1);
    bus.key_in = '0;
    wait_done(cyc);
    check("b2b_latency", 128'(cyc), 128'd10);
    @(posedge clk);
    #1;
    check("b2b_ready",     bus.key_ready,  1'b1);
    check("b2b_kv_before", bus.keys_valid, 1'b1);
    check("b2b_old_rk10",  bus.rk_data,    B_RK10);
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    check("b2b_kv_drop", bus.keys_valid, 1'b0);
    check("b2b_busy",    bus.busy,       1'b1);
    wait_done(cyc);
    check("b2b_latency2", 128'(cyc), 128'd10);
    read_rk(4'd10, d); check("b2b_new_rk10", d, ZERO_RK10);

    // 6: reset in the middle of an expansion
    start_key(KEY_FIPS, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_key_ready",  bus.key_ready,  1'b1);
    check("abort_busy",       bus.busy,       1'b0);
    check("abort_keys_valid", bus.keys_valid, 1'b0);
    check("abort_done",       bus.done,       1'b0);
    for (int a = 0; a <= 10; a++) begin
      read_rk(ADDR_W'(a), d);
      check("abort_rk_zero", d, '0);
    end
    start_key(KEY_FIPS, 1'b0);
    wait_done(cyc);
    check("rerun_latency", 128'(cyc), 128'd10);
    read_rk(4'd1, d);  check("rerun_rk1", d, FIPS_RK1);
    read_rk(4'd10, d); check("rerun_rk10", d, FIPS_RK10);

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
